branch_redirect_unit: RTL and testbench

BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

---
 rtl/branch_redirect_unit_if.sv | 22 ++
 rtl/branch_redirect_unit.sv | 145 ++++++++++++++
 tb/tb_branch_redirect_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_unit_if.sv
// Resolved-branch record handshake between the execute stage and the redirect unit.
interface branch_redirect_unit_if #(
  parameter int WIDTH = 31
);
  logic             resValid;
  logic             resReady;
  logic             resTaken;
  logic             resRedirect;
  logic [WIDTH:0]   resPC;
  logic [WIDTH:0]   resTarget;
  logic [WIDTH:0]   resPredTarget;

  modport master (
    output resValid, resTaken, resRedirect, resPC, resTarget, resPredTarget,
    input  resReady
  );

  modport slave (
    input  resValid, resTaken, resRedirect, resPC, resTarget, resPredTarget,
    output resReady
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: buffers resolved branches, classifies the head record,
// issues a one-cycle redirect pulse with flush, then freezes fetch while the
// pipeline drains.
module branch_redirect_unit #(
  parameter int WIDTH        = 31,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  globalReset,
  branch_redirect_unit_if.slave res,
  output logic                  mispredict,
  output logic                  misdirect,
  output logic                  seqRestore,
  output logic [WIDTH:0]        targetAddress,
  output logic [WIDTH:0]        oldPC,
  output logic                  flush,
  output logic                  freeze,
  output logic [15:0]           redirectCount
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  typedef enum logic [1:0] {K_CORRECT, K_RESTORE, K_MISPREDICT, K_MISDIRECT} kind_t;

  typedef struct packed {
    logic           taken;
    logic           redir;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] target;
    logic [WIDTH:0] pred;
  } entry_t;

  state_t      r_state, w_state_next;
  kind_t       r_kind, w_kind;
  entry_t      r_mem [2];
  entry_t      w_head;
  logic        r_wptr, r_rptr;
  logic [1:0]  r_count;
  logic [3:0]  r_drain_cnt;
  logic [WIDTH:0] r_target, r_oldpc;
  logic [15:0] r_redirect_count;
  logic        w_classify, w_redirect_go, w_deq, w_enq, w_ready;

  // Head classification and handshake decode
  always_comb begin
    w_head = r_mem[r_rptr];
    w_kind = K_CORRECT;
    if (w_head.redir && !w_head.taken)
      w_kind = K_RESTORE;
    else if (!w_head.redir && w_head.taken)
      w_kind = K_MISPREDICT;
    else if (w_head.redir && w_head.taken && (w_head.target != w_head.pred))
      w_kind = K_MISDIRECT;
    w_ready       = (r_count != 2'd2) && (r_state == IDLE);
    w_enq         = res.resValid && w_ready;
    w_classify    = (r_state == IDLE) && (r_count != 2'd0);
    w_redirect_go = w_classify && (w_kind != K_CORRECT);
    w_deq         = w_classify && (w_kind == K_CORRECT);
  end

  // FIFO storage; a redirect clear suppresses the write of an incoming record
  always_ff @(posedge clk) begin
    if (w_enq && !w_redirect_go)
      r_mem[r_wptr] <= '{taken: res.resTaken, redir: res.resRedirect, pc: res.resPC,
                         target: res.resTarget, pred: res.resPredTarget};
  end

  // FIFO pointers and occupancy; the clear takes priority over enqueue/dequeue
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else if (w_redirect_go) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  // State register
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_redirect_go) w_state_next = REDIRECT;
      REDIRECT: w_state_next = DRAIN;
      DRAIN:    if (r_drain_cnt <= 4'd1) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Drain down-counter, loaded while leaving REDIRECT
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset)
      r_drain_cnt <= '0;
    else if (r_state == REDIRECT)
      r_drain_cnt <= 4'(DRAIN_CYCLES);
    else if (r_state == DRAIN && r_drain_cnt != 4'd0)
      r_drain_cnt <= r_drain_cnt - 4'd1;
  end

  // Capture redirect kind and correction address on entry to REDIRECT
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      r_kind   <= K_CORRECT;
      r_target <= '0;
      r_oldpc  <= '0;
    end else if (w_redirect_go) begin
      r_kind <= w_kind;
      if (w_kind == K_RESTORE) r_oldpc  <= w_head.pc;
      else                     r_target <= w_head.target;
    end
  end

  // Saturating redirect counter
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset)
      r_redirect_count <= '0;
    else if (w_redirect_go && r_redirect_count != 16'hFFFF)
      r_redirect_count <= r_redirect_count + 16'd1;
  end

  // Outputs decoded from state so reset removes pulses and freeze at once
  always_comb begin
    res.resReady  = w_ready;
    flush         = (r_state == REDIRECT);
    mispredict    = flush && (r_kind == K_MISPREDICT);
    misdirect     = flush && (r_kind == K_MISDIRECT);
    seqRestore    = flush && (r_kind == K_RESTORE);
    freeze        = (r_state == DRAIN);
    targetAddress = r_target;
    oldPC         = r_oldpc;
    redirectCount = r_redirect_count;
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit (DRAIN_CYCLES = 2).
// Inputs change and outputs are sampled just after the falling edge.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        globalReset = 1'b1;
  logic        mispredict, misdirect, seqRestore, flush, freeze;
  logic [31:0] targetAddress, oldPC;
  logic [15:0] redirectCount;
  int          vectors = 0;
  int          miscompares = 0;

  branch_redirect_unit_if #(.WIDTH(31)) bus ();

  branch_redirect_unit #(.WIDTH(31), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .globalReset(globalReset), .res(bus),
    .mispredict(mispredict), .misdirect(misdirect), .seqRestore(seqRestore),
    .targetAddress(targetAddress), .oldPC(oldPC), .flush(flush),
    .freeze(freeze), .redirectCount(redirectCount)
  );

  always #5 clk = ~clk;

  task automatic offer(input logic redir, input logic taken, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [31:0] pred);
    bus.resValid      = 1'b1;
    bus.resRedirect   = redir;
    bus.resTaken      = taken;
    bus.resPC         = pc;
    bus.resTarget     = tgt;
    bus.resPredTarget = pred;
  endtask

  task automatic quiet();
    bus.resValid = 1'b0;
  endtask

  // Offer one record, then walk through REDIRECT and two DRAIN cycles back to IDLE.
  task automatic run_mispredict(input logic [31:0] tgt);
    @(negedge clk); offer(1'b0, 1'b1, 32'h0, tgt, 32'h0);
    @(negedge clk); quiet();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    if ({mispredict, misdirect, seqRestore, flush, freeze} !== 5'b0) begin
      miscompares++; $display("FAIL rst_pulses: got %b want 00000", {mispredict, misdirect, seqRestore, flush, freeze});
    end
    vectors++;
    if (targetAddress !== 32'h0 || oldPC !== 32'h0) begin
      miscompares++; $display("FAIL rst_addr: got %h/%h want 0/0", targetAddress, oldPC);
    end
    vectors++;
    if (redirectCount !== 16'h0) begin
      miscompares++; $display("FAIL rst_count: got %h want 0", redirectCount);
    end
    vectors++;
    globalReset = 1'b0;
    #1;
    if (bus.resReady !== 1'b1) begin
      miscompares++; $display("FAIL rst_ready: got %b want 1", bus.resReady);
    end
    vectors++;
  endtask

  task automatic test_mispredict();
    @(negedge clk); offer(1'b0, 1'b1, 32'h8, 32'h40, 32'h9);
    if (bus.resReady !== 1'b1) begin
      miscompares++; $display("FAIL mp_ready_in: got %b want 1", bus.resReady);
    end
    vectors++;
    @(negedge clk); quiet();
    if (flush !== 1'b0) begin
      miscompares++; $display("FAIL mp_early: flush got %b want 0", flush);
    end
    vectors++;
    @(negedge clk);
    if ({mispredict, misdirect, seqRestore, flush, freeze} !== 5'b10010) begin
      miscompares++; $display("FAIL mp_pulse: got %b want 10010", {mispredict, misdirect, seqRestore, flush, freeze});
    end
    vectors++;
    if (targetAddress !== 32'h40) begin
      miscompares++; $display("FAIL mp_target: got %h want 40", targetAddress);
    end
    vectors++;
    if (bus.resReady !== 1'b0) begin
      miscompares++; $display("FAIL mp_ready_redirect: got %b want 0", bus.resReady);
    end
    vectors++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if ({mispredict, flush, freeze, bus.resReady} !== 4'b0010) begin
        miscompares++; $display("FAIL mp_drain%0d: got %b want 0010", i, {mispredict, flush, freeze, bus.resReady});
      end
      vectors++;
    end
    @(negedge clk);
    if ({freeze, bus.resReady} !== 2'b01) begin
      miscompares++; $display("FAIL mp_idle: got %b want 01", {freeze, bus.resReady});
    end
    vectors++;
    if (redirectCount !== 16'd1) begin
      miscompares++; $display("FAIL mp_count: got %0d want 1", redirectCount);
    end
    vectors++;
  endtask

  task automatic test_restore();
    @(negedge clk); offer(1'b1, 1'b0, 32'h10, 32'h99, 32'h20);
    @(negedge clk); quiet();
    @(negedge clk);
    if ({mispredict, misdirect, seqRestore, flush} !== 4'b0011) begin
      miscompares++; $display("FAIL rs_pulse: got %b want 0011", {mispredict, misdirect, seqRestore, flush});
    end
    vectors++;
    if (oldPC !== 32'h10) begin
      miscompares++; $display("FAIL rs_oldpc: got %h want 10", oldPC);
    end
    vectors++;
    if (targetAddress !== 32'h40) begin
      miscompares++; $display("FAIL rs_target_hold: got %h want 40", targetAddress);
    end
    vectors++;
    repeat (3) @(negedge clk);
    if (oldPC !== 32'h10 || seqRestore !== 1'b0) begin
      miscompares++; $display("FAIL rs_after: oldPC %h seqRestore %b want 10/0", oldPC, seqRestore);
    end
    vectors++;
  endtask

  task automatic test_misdirect();
    @(negedge clk); offer(1'b1, 1'b1, 32'h30, 32'h80, 32'h84);
    @(negedge clk); quiet();
    @(negedge clk);
    if ({mispredict, misdirect, seqRestore, flush} !== 4'b0101) begin
      miscompares++; $display("FAIL md_pulse: got %b want 0101", {mispredict, misdirect, seqRestore, flush});
    end
    vectors++;
    if (targetAddress !== 32'h80) begin
      miscompares++; $display("FAIL md_target: got %h want 80", targetAddress);
    end
    vectors++;
    repeat (3) @(negedge clk);
    if (redirectCount !== 16'd3) begin
      miscompares++; $display("FAIL md_count: got %0d want 3", redirectCount);
    end
    vectors++;
  endtask

  // Correct predictions stream at one per cycle with no pulse and no stall.
  task automatic test_correct_back_to_back();
    logic [3:0] rd [4];
    logic [3:0] tk [4];
    rd[0] = 1'b1; tk[0] = 1'b1;   // taken, equal targets
    rd[1] = 1'b0; tk[1] = 1'b0;   // not taken as predicted
    rd[2] = 1'b1; tk[2] = 1'b1;
    rd[3] = 1'b0; tk[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); offer(rd[i][0], tk[i][0], 32'h100 + i, 32'h80, 32'h80);
      if (bus.resReady !== 1'b1 || flush !== 1'b0) begin
        miscompares++; $display("FAIL cr_stream%0d: ready %b flush %b want 1/0", i, bus.resReady, flush);
      end
      vectors++;
    end
    @(negedge clk); quiet();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({mispredict, misdirect, seqRestore, flush, freeze} !== 5'b0) begin
        miscompares++; $display("FAIL cr_quiet%0d: got %b want 00000", i, {mispredict, misdirect, seqRestore, flush, freeze});
      end
      vectors++;
    end
    if (redirectCount !== 16'd3 || targetAddress !== 32'h80) begin
      miscompares++; $display("FAIL cr_state: count %0d target %h want 3/80", redirectCount, targetAddress);
    end
    vectors++;
  endtask

  // A wrong-path record arriving behind a redirecting head must vanish.
  task automatic test_flush_younger(input logic second_is_restore);
    @(negedge clk); offer(1'b0, 1'b1, 32'h50, 32'h120, 32'h0);
    @(negedge clk); offer(second_is_restore, 1'b0, 32'h60, 32'h200, 32'h200);
    if (bus.resReady !== 1'b1) begin
      miscompares++; $display("FAIL fy_ready2: got %b want 1", bus.resReady);
    end
    vectors++;
    @(negedge clk); quiet();
    if (mispredict !== 1'b1 || targetAddress !== 32'h120) begin
      miscompares++; $display("FAIL fy_pulse: mp %b target %h want 1/120", mispredict, targetAddress);
    end
    vectors++;
    @(negedge clk);
    if (dut.r_count !== 2'd0) begin
      miscompares++; $display("FAIL fy_fifo_empty: got %0d want 0", dut.r_count);
    end
    vectors++;
    // The FIFO cannot fill in this design (the head resolves every IDLE cycle),
    // so resReady low is exercised through the recovery states.
    if (bus.resReady !== 1'b0) begin
      miscompares++; $display("FAIL fy_ready_drain: got %b want 0", bus.resReady);
    end
    vectors++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({mispredict, misdirect, seqRestore, flush} !== 4'b0) begin
        miscompares++; $display("FAIL fy_no_second%0d: got %b want 0000", i, {mispredict, misdirect, seqRestore, flush});
      end
      vectors++;
    end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); offer(1'b0, 1'b1, 32'h0, 32'h300, 32'h0);
    @(negedge clk); quiet();
    repeat (2) @(negedge clk);
    if (freeze !== 1'b1) begin
      miscompares++; $display("FAIL rd_in_drain: freeze got %b want 1", freeze);
    end
    vectors++;
    #2 globalReset = 1'b1;
    #1;
    if ({freeze, flush, mispredict} !== 3'b000) begin
      miscompares++; $display("FAIL rd_abort: got %b want 000", {freeze, flush, mispredict});
    end
    vectors++;
    if (redirectCount !== 16'h0 || targetAddress !== 32'h0) begin
      miscompares++; $display("FAIL rd_clear: count %h target %h want 0/0", redirectCount, targetAddress);
    end
    vectors++;
    @(negedge clk); globalReset = 1'b0;
    #1;
    if (bus.resReady !== 1'b1) begin
      miscompares++; $display("FAIL rd_ready: got %b want 1", bus.resReady);
    end
    vectors++;
    repeat (3) @(negedge clk);
    if ({freeze, flush} !== 2'b00) begin
      miscompares++; $display("FAIL rd_residual: got %b want 00", {freeze, flush});
    end
    vectors++;
  endtask

  // The counter is preset near its limit; three redirects must stop at FFFF.
  task automatic test_saturation();
    @(negedge clk);
    force dut.r_redirect_count = 16'hFFFD;
    #1 release dut.r_redirect_count;
    run_mispredict(32'h400);
    if (redirectCount !== 16'hFFFE) begin
      miscompares++; $display("FAIL sat_fffe: got %h want fffe", redirectCount);
    end
    vectors++;
    run_mispredict(32'h404);
    if (redirectCount !== 16'hFFFF) begin
      miscompares++; $display("FAIL sat_ffff: got %h want ffff", redirectCount);
    end
    vectors++;
    run_mispredict(32'h408);
    if (redirectCount !== 16'hFFFF || targetAddress !== 32'h408) begin
      miscompares++; $display("FAIL sat_hold: count %h target %h want ffff/408", redirectCount, targetAddress);
    end
    vectors++;
  endtask

  initial begin
    bus.resValid      = 1'b0;
    bus.resRedirect   = 1'b0;
    bus.resTaken      = 1'b0;
    bus.resPC         = '0;
    bus.resTarget     = '0;
    bus.resPredTarget = '0;
    test_reset();
    test_mispredict();
    test_restore();
    test_misdirect();
    test_correct_back_to_back();
    test_flush_younger(1'b0);
    test_flush_younger(1'b1);
    test_reset_mid_drain();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
